// File: rtl/conv5x5_mac_core_pkg.sv
// Shared definitions for the 5x5 convolution MAC core.
// Holds the FSM state encoding, the default tap count and the helper that
// derives the accumulator width, so every file sizes its datapath the same way.
package conv5x5_mac_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int KX_DEF = 5;
    localparam int KY_DEF = 5;
    localparam int TAPS   = KX_DEF * KY_DEF;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2i(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Product width plus growth for every tap plus one guard bit for the bias.
    function automatic int acc_width(input int i_f_bw, input int w_bw, input int taps);
        return i_f_bw + w_bw + 1 + clog2i(taps) + 1;
    endfunction

    localparam int ACC_W = acc_width(8, 8, TAPS);

endpackage

// File: rtl/conv5x5_mac_core_if.sv
// Handshake bundle between a producer (weight loader + line buffer) and the
// convolution core.
//   master: drives weight load, weight beats, bias and windows; receives
//           o_w_loaded, o_out_valid, o_out_pixel.
//   slave : the core side of the same signals.
interface conv5x5_mac_core_if #(
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int B_BW   = 16,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int O_F_BW = 8
) ();

    logic                       i_w_load_start;
    logic                       i_w_valid;
    logic signed [W_BW-1:0]     i_w_data;
    logic signed [B_BW-1:0]     i_bias;
    logic                       i_window_valid;
    logic [KX*KY*I_F_BW-1:0]    i_window;
    logic                       o_w_loaded;
    logic                       o_out_valid;
    logic [O_F_BW-1:0]          o_out_pixel;

    modport master (
        output i_w_load_start, i_w_valid, i_w_data, i_bias, i_window_valid, i_window,
        input  o_w_loaded, o_out_valid, o_out_pixel
    );

    modport slave (
        input  i_w_load_start, i_w_valid, i_w_data, i_bias, i_window_valid, i_window,
        output o_w_loaded, o_out_valid, o_out_pixel
    );

endinterface

// File: rtl/conv5x5_mac_core_conv_row_sum.sv
// conv_row_sum: adds the KX signed products of one window row and registers
// the result (one pipeline stage).
//   clk, reset_n : clock, asynchronous active-low reset
//   prods        : KX packed signed products, product kx at bit kx*P_W
//   row_sum      : registered signed row total
module conv_row_sum
    import conv5x5_mac_core_pkg::*;
#(
    parameter int P_W = 17,
    parameter int KX  = 5,
    parameter int S_W = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [KX*P_W-1:0]       prods,
    output logic signed [S_W-1:0]   row_sum
);

    logic signed [S_W-1:0] sum_s;

    // Sign-extend each product to the row width and add them up.
    always_comb begin
        sum_s = '0;
        for (int kx = 0; kx < KX; kx++) begin
            sum_s = sum_s + S_W'($signed(prods[kx*P_W +: P_W]));
        end
    end

    // Row-sum pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_sum <= '0;
        end else begin
            row_sum <= sum_s;
        end
    end

endmodule

// File: rtl/conv5x5_mac_core.sv
// conv5x5_mac_core: loads KX*KY signed weights plus a bias, then convolves
// one unsigned KX x KY window per cycle, producing a ReLU'd, clamped pixel
// four cycles after the window is accepted.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : weight load / window inputs, o_w_loaded / result outputs
// Pipeline: accept register -> products -> row sums -> total+bias -> shift/clamp.
module conv5x5_mac_core
    import conv5x5_mac_core_pkg::*;
#(
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int B_BW   = 16,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int SHIFT  = 0,
    parameter int O_F_BW = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    conv5x5_mac_core_if.slave       bus
);

    localparam int N_TAPS = KX * KY;
    localparam int IDX_W  = clog2i(N_TAPS);
    localparam int P_W    = I_F_BW + W_BW + 1;
    localparam int S_W    = P_W + clog2i(KX);
    localparam int A_W    = acc_width(I_F_BW, W_BW, N_TAPS);
    localparam logic signed [A_W-1:0] O_MAX_A = A_W'((1 << O_F_BW) - 1);

    state_t                     state_r;
    logic [IDX_W-1:0]           idx_r;
    logic                       w_loaded_r;
    logic signed [W_BW-1:0]     weight_r [N_TAPS];
    logic signed [B_BW-1:0]     bias_r;

    logic                       accept_s;
    logic [3:0]                 valid_r;
    logic [N_TAPS*I_F_BW-1:0]   win_r;
    logic [KY-1:0][KX*P_W-1:0]  prod_s;
    logic [KY-1:0][KX*P_W-1:0]  prod_r;
    logic signed [P_W-1:0]      pix_ext_s;
    logic signed [P_W-1:0]      w_ext_s;
    logic signed [S_W-1:0]      row_sum_s [KY];
    logic signed [A_W-1:0]      total_s;
    logic signed [A_W-1:0]      total_r;
    logic                       out_valid_r;
    logic [O_F_BW-1:0]          out_pixel_r;

    // Arithmetic shift, negative results to zero, saturate at the output max.
    function automatic logic [O_F_BW-1:0] relu_clamp(input logic signed [A_W-1:0] t);
        logic signed [A_W-1:0] s;
        logic [O_F_BW-1:0]     r;
        s = t >>> SHIFT;
        if (s[A_W-1]) begin
            r = '0;
        end else if (s > O_MAX_A) begin
            r = {O_F_BW{1'b1}};
        end else begin
            r = s[O_F_BW-1:0];
        end
        return r;
    endfunction

    // Load start outranks everything, including a coincident window.
    assign accept_s = (state_r == READY) && bus.i_window_valid && !bus.i_w_load_start;

    // Control FSM: weight/bias capture and the registered loaded flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            w_loaded_r <= 1'b0;
            bias_r     <= '0;
            for (int t = 0; t < N_TAPS; t++) begin
                weight_r[t] <= '0;
            end
        end else if (bus.i_w_load_start) begin
            state_r    <= LOAD;
            idx_r      <= '0;
            w_loaded_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                LOAD: begin
                    if (bus.i_w_valid) begin
                        weight_r[idx_r] <= bus.i_w_data;
                        if (idx_r == IDX_W'(N_TAPS - 1)) begin
                            bias_r     <= bus.i_bias;
                            state_r    <= READY;
                            idx_r      <= '0;
                            w_loaded_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                READY: begin
                    state_r <= READY;
                end
                default: begin
                    state_r    <= IDLE;
                    idx_r      <= '0;
                    w_loaded_r <= 1'b0;
                end
            endcase
        end
    end

    // Zero-extend each pixel, sign-extend its weight, multiply; grouped by row.
    always_comb begin
        prod_s    = '0;
        pix_ext_s = '0;
        w_ext_s   = '0;
        for (int t = 0; t < N_TAPS; t++) begin
            pix_ext_s = {{(W_BW + 1){1'b0}}, win_r[t*I_F_BW +: I_F_BW]};
            w_ext_s   = {{(I_F_BW + 1){weight_r[t][W_BW-1]}}, weight_r[t]};
            prod_s[t / KX][(t % KX)*P_W +: P_W] = pix_ext_s * w_ext_s;
        end
    end

    for (genvar ky = 0; ky < KY; ky++) begin : g_row
        conv_row_sum #(
            .P_W (P_W),
            .KX  (KX),
            .S_W (S_W)
        ) u_row (
            .clk     (clk),
            .reset_n (reset_n),
            .prods   (prod_r[ky]),
            .row_sum (row_sum_s[ky])
        );
    end

    // Add the row sums to the sign-extended bias.
    always_comb begin
        total_s = A_W'(bias_r);
        for (int ky = 0; ky < KY; ky++) begin
            total_s = total_s + A_W'(row_sum_s[ky]);
        end
    end

    // Datapath registers: window capture, products, total.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_r   <= '0;
            prod_r  <= '0;
            total_r <= '0;
        end else begin
            if (accept_s) begin
                win_r <= bus.i_window;
            end
            prod_r  <= prod_s;
            total_r <= total_s;
        end
    end

    // Valid chain and output register; a reload flushes everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r     <= 4'b0000;
            out_valid_r <= 1'b0;
            out_pixel_r <= '0;
        end else if (bus.i_w_load_start) begin
            valid_r     <= 4'b0000;
            out_valid_r <= 1'b0;
        end else begin
            valid_r     <= {valid_r[2:0], accept_s};
            out_valid_r <= valid_r[3];
            if (valid_r[3]) begin
                out_pixel_r <= relu_clamp(total_r);
            end
        end
    end

    assign bus.o_w_loaded  = w_loaded_r;
    assign bus.o_out_valid = out_valid_r;
    assign bus.o_out_pixel = out_pixel_r;

endmodule

// File: tb/tb_conv5x5_mac_core.sv
// Directed, scoreboard-based bench for conv5x5_mac_core.
module tb_conv5x5_mac_core;

    localparam int I_F_BW = 8;
    localparam int W_BW   = 8;
    localparam int B_BW   = 16;
    localparam int KX     = 5;
    localparam int KY     = 5;
    localparam int SHIFT  = 0;
    localparam int O_F_BW = 8;
    localparam int TAPS   = KX * KY;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   w_m [TAPS];
    int   pix_m [TAPS];
    int   bias_m = 0;
    exp_t exp_q [$];
    exp_t mon_e;
    logic [31:0] mon_have;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    conv5x5_mac_core_if #(
        .I_F_BW (I_F_BW), .W_BW (W_BW), .B_BW (B_BW),
        .KX (KX), .KY (KY), .O_F_BW (O_F_BW)
    ) bus ();

    conv5x5_mac_core #(
        .I_F_BW (I_F_BW), .W_BW (W_BW), .B_BW (B_BW),
        .KX (KX), .KY (KY), .SHIFT (SHIFT), .O_F_BW (O_F_BW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Reference: bias + sum(pixel*weight), shift, ReLU, clamp.
    function automatic int model();
        int s;
        s = bias_m;
        for (int t = 0; t < TAPS; t++) s += pix_m[t] * w_m[t];
        s = s >>> SHIFT;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    // Scoreboard: every result pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (bus.o_out_valid === 1'b1) begin
            mon_have = (exp_q.size() != 0) ? 32'd1 : 32'd0;
            chk("spurious_valid", mon_have, 32'd1);
            if (mon_have == 32'd1) begin
                mon_e = exp_q.pop_front();
                chk("out_pixel", 32'(bus.o_out_pixel), 32'(mon_e.val));
                chk("out_latency", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_weights(input int v);
        for (int t = 0; t < TAPS; t++) w_m[t] = v;
    endtask

    task automatic set_pix(input int v);
        for (int t = 0; t < TAPS; t++) pix_m[t] = v;
    endtask

    task automatic drive_window(input bit expect_out);
        exp_t e;
        for (int t = 0; t < TAPS; t++) bus.i_window[t*I_F_BW +: I_F_BW] = 8'(pix_m[t]);
        bus.i_window_valid = 1'b1;
        tick();
        if (expect_out) begin
            e.val = model();
            e.due = cyc + 4;
            exp_q.push_back(e);
        end
    endtask

    task automatic window_off();
        bus.i_window_valid = 1'b0;
    endtask

    task automatic load_start();
        bus.i_w_load_start = 1'b1;
        tick();
        bus.i_w_load_start = 1'b0;
    endtask

    task automatic beats(input int from, input int to);
        for (int i = from; i < to; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w_data  = 8'(w_m[i]);
            bus.i_bias    = (i == TAPS - 1) ? 16'(bias_m) : 16'h7abc;
            tick();
        end
        bus.i_w_valid = 1'b0;
        bus.i_bias    = 16'h5555;
    endtask

    task automatic load_all();
        load_start();
        beats(0, TAPS);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n            = 1'b0;
        bus.i_w_load_start = 1'b0;
        bus.i_w_valid      = 1'b0;
        bus.i_w_data       = '0;
        bus.i_bias         = '0;
        bus.i_window_valid = 1'b0;
        bus.i_window       = '0;
        idle(3);
        chk("rst_w_loaded", 32'(bus.o_w_loaded), 32'd0);
        chk("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        chk("rst_out_pixel", 32'(bus.o_out_pixel), 32'd0);
        reset_n = 1'b1;
        tick();

        // Windows in IDLE are dropped.
        set_pix(7);
        drive_window(1'b0);
        window_off();
        idle(8);
        chk("idle_w_loaded", 32'(bus.o_w_loaded), 32'd0);

        // All-ones weights and window.
        set_weights(1);
        bias_m = 0;
        load_start();
        chk("in_load_w_loaded", 32'(bus.o_w_loaded), 32'd0);
        beats(0, TAPS);
        chk("loaded_flag", 32'(bus.o_w_loaded), 32'd1);
        set_pix(1);
        drive_window(1'b1);
        window_off();
        idle(8);
        chk("hold_pixel", 32'(bus.o_out_pixel), 32'd25);
        chk("hold_valid_low", 32'(bus.o_out_valid), 32'd0);

        // Saturation: 25*127*255 clamps to 255.
        set_weights(127);
        load_all();
        set_pix(255);
        drive_window(1'b1);
        window_off();
        idle(6);

        // ReLU: -25 + 10 -> 0.
        set_weights(-1);
        bias_m = 10;
        load_all();
        set_pix(1);
        drive_window(1'b1);
        window_off();
        idle(6);
        chk("relu_hold", 32'(bus.o_out_pixel), 32'd0);

        // Ten back-to-back windows 0..9.
        set_weights(1);
        bias_m = 0;
        load_all();
        for (int p = 0; p < 10; p++) begin
            set_pix(p);
            drive_window(1'b1);
        end
        window_off();
        idle(8);

        // Mixed-sign weights, distinct pixels, back-to-back.
        for (int t = 0; t < TAPS; t++) w_m[t] = int'($urandom_range(4)) - 2;
        bias_m = 100;
        load_all();
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < TAPS; t++) pix_m[t] = int'($urandom_range(9));
            drive_window(1'b1);
        end
        window_off();
        idle(8);

        // Load start coinciding with a weight beat: the beat is dropped.
        set_weights(2);
        bias_m = 0;
        bus.i_w_load_start = 1'b1;
        bus.i_w_valid      = 1'b1;
        bus.i_w_data       = 8'd100;
        tick();
        bus.i_w_load_start = 1'b0;
        bus.i_w_valid      = 1'b0;
        beats(0, TAPS - 1);
        chk("coincide_24_beats", 32'(bus.o_w_loaded), 32'd0);
        beats(TAPS - 1, TAPS);
        chk("coincide_25_beats", 32'(bus.o_w_loaded), 32'd1);
        set_pix(1);
        drive_window(1'b1);
        window_off();
        idle(6);

        // Reload two cycles after acceptance discards that window.
        set_pix(3);
        drive_window(1'b0);
        window_off();
        tick();
        set_weights(1);
        load_start();
        chk("reload_w_loaded", 32'(bus.o_w_loaded), 32'd0);
        idle(6);
        beats(0, TAPS - 1);
        chk("reload_24_beats", 32'(bus.o_w_loaded), 32'd0);
        beats(TAPS - 1, TAPS);
        chk("reload_25_beats", 32'(bus.o_w_loaded), 32'd1);

        // Windows during LOAD are dropped.
        load_start();
        set_pix(3);
        drive_window(1'b0);
        drive_window(1'b0);
        window_off();
        beats(0, TAPS);
        idle(6);
        set_pix(2);
        drive_window(1'b1);
        window_off();
        idle(6);

        // Reset while results are streaming out.
        for (int k = 0; k < 6; k++) begin
            set_pix(k + 1);
            drive_window(k < 2);
        end
        #1;
        chk("pre_reset_valid", 32'(bus.o_out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_out_valid", 32'(bus.o_out_valid), 32'd0);
        chk("reset_w_loaded", 32'(bus.o_w_loaded), 32'd0);
        chk("reset_out_pixel", 32'(bus.o_out_pixel), 32'd0);
        window_off();
        tick();
        reset_n = 1'b1;
        set_pix(5);
        drive_window(1'b0);
        drive_window(1'b0);
        window_off();
        idle(10);
        chk("post_reset_w_loaded", 32'(bus.o_w_loaded), 32'd0);
        chk("post_reset_valid", 32'(bus.o_out_valid), 32'd0);
        load_all();
        set_pix(4);
        drive_window(1'b1);
        window_off();
        idle(8);

        chk("pending_results", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
